mem_arbiter: RTL
================

# mem_arbiter

Arbitrates the single shared main-memory port of the 16-bit CPU between the instruction-cache miss path and the data-cache miss/write-through path. It sequences 8-word block fills out of a pipelined, fixed-latency memory and single-word write-through stores. It returns fill data word by word to the requesting cache and pulses a per-requester done signal. The block sits between the two cache controllers and the memory model, below the fetch and memory stages.

## Interface
- WORDS_PER_BLOCK, 8: words per cache block (16-bit words, byte-addressed, so the block is 16 bytes)
- MEM_LATENCY, 4: cycles from memory read issue to `mem_data_valid`
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- ic_req  in  1  I-cache fill request; held high with `ic_addr` stable until `ic_done`
- ic_addr  in  16  I-cache miss byte address
- dc_req  in  1  D-cache request; held high with `dc_addr`, `dc_wr` and `dc_wdata` stable until `dc_done`
- dc_wr  in  1  1 = single-word write-through, 0 = block fill
- dc_addr  in  16  D-cache byte address
- dc_wdata  in  16  store data
- mem_en  out  1  memory access strobe, one access per cycle
- mem_wr  out  1  write enable, qualified by `mem_en`
- mem_addr  out  16  memory byte address
- mem_wdata  out  16  memory write data
- mem_rdata  in  16  memory read data
- mem_data_valid  in  1  `mem_rdata` valid this cycle
- fill_valid  out  1  `fill_data` valid for the granted requester
- fill_dst  out  1  0 = I-cache, 1 = D-cache
- fill_idx  out  3  word index within the block
- fill_data  out  16  fill word
- ic_done  out  1  one-cycle pulse: I-cache transaction complete
- dc_done  out  1  one-cycle pulse: D-cache transaction complete
- busy  out  1  state is not IDLE

## Operation
- States are IDLE, WRITE and FILL.
- **IDLE:** sample `ic_req` and `dc_req`.
  - If only one is high, grant it.
  - If both are high, grant the requester that was not granted last. The `last_grant` flag resets to I, so D wins the first tie.
  - A D request with `dc_wr=1` goes to WRITE.
  - Any other granted request goes to FILL. The granted address is latched.
- **WRITE:** one cycle.
  - `mem_en=1`, `mem_wr=1`, `mem_addr` = latched address, `mem_wdata` = latched data, `dc_done=1`.
  - Next state is IDLE.
- **FILL:** block base = latched address & 0xFFF0.
  - Issue counter `ic_cnt` runs 0..7.
    - Each cycle while `ic_cnt` < 8: `mem_en=1`, `mem_wr=0`, `mem_addr` = base + 2·`ic_cnt`, then increment `ic_cnt`.
  - Return counter `rc_cnt` runs 0..7.
    - On each `mem_data_valid`: `fill_valid=1`, `fill_idx=rc_cnt`, `fill_data=mem_rdata`, `fill_dst` = grantee, then increment `rc_cnt`.
  - On the return with `rc_cnt==7`: assert the grantee's done signal in the same cycle and go to IDLE.
- Transactions are never preempted. Deasserting a request mid-transaction is illegal and is ignored: the transaction completes.
- `mem_data_valid` outside FILL is ignored; no `fill_valid` is produced.
- Reset values: state IDLE, both counters 0, `last_grant`=I, and every output 0 (`mem_addr`, `mem_wdata`, `fill_*` included).
- Reset mid-operation aborts to IDLE with no done pulse. The memory model shares `rst_n`, so no stale returns arrive after reset.

## Timing
- All outputs are driven from registered state and counters, with no combinational path from `*_req` to `mem_*`. `fill_*` and the `*_done` signals are the one exception: they are combinational from `mem_data_valid`/`mem_rdata` qualified by state.
- Fill timing, with cycle 0 = IDLE cycle that grants:
  - Issues occur in cycles 1..8.
  - Returns occur in cycles 1+MEM_LATENCY .. 8+MEM_LATENCY (5..12 by default).
  - The done pulse occurs in cycle 12.
  - The next grant is possible in cycle 13.
- Write timing: the grant is in cycle 0; the memory write and `dc_done` occur in cycle 1; the next grant is possible in cycle 2.
- Back-to-back ties alternate I/D. A waiting requester is granted within one transaction.
- Address wrap: base 0xFFF0 issues 0xFFF0..0xFFFE. There is no carry out of the block.

## Structure
- Package `mem_arb_pkg`:
  - state enum {IDLE, WRITE, FILL}
  - requester ID constants REQ_I=0, REQ_D=1
  - BLOCK_MASK=16'hFFF0
  - WORDS_PER_BLOCK
- Single module. There is no natural sub-module: the counters and the FSM are tightly coupled.
- The memory model used by the bench is a separate pipelined `mem_model` with a MEM_LATENCY parameter.

## Test plan
- I fill only: `ic_req=1`, `ic_addr=0x1234`.
  - Required: `mem_addr` 0x1230..0x123E in cycles 1..8.
  - Required: `fill_idx` 0..7 with `fill_dst=0` in cycles 5..12.
  - Required: `ic_done` in cycle 12, and `busy` low in cycle 13.
- Simultaneous fills: `ic_req` and `dc_req` both asserted at reset release.
  - Required: D served first, with `dc_done` in cycle 12.
  - Required: I granted in cycle 13, with `ic_done` in cycle 25.
  - Required: the next tie goes to D.
- D write: `dc_wr=1`, `dc_addr=0x00A2`, `dc_wdata=0xBEEF`.
  - Required: one cycle with `mem_en=1`, `mem_wr=1`, `mem_addr=0x00A2`, `mem_wdata=0xBEEF`, `dc_done=1`.
  - Required: no `fill_valid`.
- Wrap: I fill at 0xFFFA.
  - Required: addresses 0xFFF0..0xFFFE.
  - Required: fill data matches the memory image.
- Reset mid-fill: assert `rst_n=0` in cycle 6.
  - Required: next cycle all outputs 0, state IDLE, no done pulse.
  - Required: a fresh request afterwards completes normally.
- Spurious `mem_data_valid` in IDLE.
  - Required: `fill_valid` stays 0.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared constants and types for the main-memory arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    FILL  = 2'd2
  } state_e;

  // Requester identifiers, also the encoding of fill_dst
  localparam logic REQ_I = 1'b0;
  localparam logic REQ_D = 1'b1;

  localparam logic [15:0] BLOCK_MASK      = 16'hFFF0;
  localparam int          WORDS_PER_BLOCK = 8;
  localparam int          MEM_LATENCY     = 4;

  // Word index width within a block, and issue-counter width (needs to reach WORDS_PER_BLOCK)
  localparam int IDX_W = $clog2(WORDS_PER_BLOCK);
  localparam int CNT_W = IDX_W + 1;

endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates the shared memory port between I-cache fills and D-cache
// fills / write-through stores. Fills are issued one word per cycle to a
// pipelined fixed-latency memory; returns are forwarded word by word.
module mem_arbiter
  import mem_arb_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ic_req,
  input  logic [15:0] ic_addr,
  input  logic        dc_req,
  input  logic        dc_wr,
  input  logic [15:0] dc_addr,
  input  logic [15:0] dc_wdata,
  output logic        mem_en,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        mem_data_valid,
  output logic        fill_valid,
  output logic        fill_dst,
  output logic [2:0]  fill_idx,
  output logic [15:0] fill_data,
  output logic        ic_done,
  output logic        dc_done,
  output logic        busy
);

  localparam logic [CNT_W-1:0] ISSUE_END = CNT_W'(WORDS_PER_BLOCK);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(WORDS_PER_BLOCK - 1);

  state_e             state_q;
  logic [CNT_W-1:0]   ic_cnt_q;
  logic [IDX_W-1:0]   rc_cnt_q;
  logic               last_grant_q;
  logic               grant_q;
  logic [15:0]        addr_q;
  logic [15:0]        wdata_q;
  logic               grant_d;
  logic [15:0]        base;

  // Tie goes to whoever was not served last; otherwise the sole requester
  assign grant_d = (ic_req && dc_req) ? ~last_grant_q : dc_req;
  assign base    = addr_q & BLOCK_MASK;
  assign busy    = (state_q != IDLE);

  // Transaction FSM with issue and return counters
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      ic_cnt_q     <= '0;
      rc_cnt_q     <= '0;
      last_grant_q <= REQ_I;
      grant_q      <= REQ_I;
      addr_q       <= '0;
      wdata_q      <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (ic_req || dc_req) begin
            grant_q      <= grant_d;
            last_grant_q <= grant_d;
            ic_cnt_q     <= '0;
            rc_cnt_q     <= '0;
            if (grant_d == REQ_D) begin
              addr_q  <= dc_addr;
              wdata_q <= dc_wdata;
              state_q <= dc_wr ? WRITE : FILL;
            end else begin
              addr_q  <= ic_addr;
              state_q <= FILL;
            end
          end
        end
        WRITE: state_q <= IDLE;
        FILL: begin
          if (ic_cnt_q < ISSUE_END) begin
            ic_cnt_q <= ic_cnt_q + 1'b1;
          end
          if (mem_data_valid) begin
            rc_cnt_q <= rc_cnt_q + 1'b1;
            if (rc_cnt_q == LAST_IDX) begin
              state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Memory strobes decode from registered state; fill/done follow the return path
  always_comb begin
    mem_en     = 1'b0;
    mem_wr     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    fill_valid = 1'b0;
    fill_dst   = 1'b0;
    fill_idx   = '0;
    fill_data  = '0;
    ic_done    = 1'b0;
    dc_done    = 1'b0;
    case (state_q)
      WRITE: begin
        mem_en    = 1'b1;
        mem_wr    = 1'b1;
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        dc_done   = 1'b1;
      end
      FILL: begin
        if (ic_cnt_q < ISSUE_END) begin
          mem_en   = 1'b1;
          // OR-in the word offset so the address never carries out of the block
          mem_addr = base | {{(16 - IDX_W - 1){1'b0}}, ic_cnt_q[IDX_W-1:0], 1'b0};
        end
        if (mem_data_valid) begin
          fill_valid = 1'b1;
          fill_dst   = grant_q;
          fill_idx   = rc_cnt_q;
          fill_data  = mem_rdata;
          if (rc_cnt_q == LAST_IDX) begin
            ic_done = (grant_q == REQ_I);
            dc_done = (grant_q == REQ_D);
          end
        end
      end
      default: ;
    endcase
  end

endmodule
